// File: rtl/vga_pkg.sv
// Shared VGA timing types and helpers for the parametrised timing generator.
package vga_pkg;

    typedef struct packed {
        int unsigned active;
        int unsigned fp;
        int unsigned sync;
        int unsigned bp;
    } axis_timing_t;

    typedef struct packed {
        axis_timing_t h;
        axis_timing_t v;
    } vga_timing_t;

    localparam vga_timing_t VGA_640x480 = '{
        h: '{active: 640, fp: 16, sync: 96, bp: 48},
        v: '{active: 480, fp: 10, sync: 2,  bp: 33}
    };

    typedef enum int unsigned {
        CM_MONO   = 0,
        CM_RGB111 = 1,
        CM_RGB332 = 2
    } color_mode_e;

    function automatic int unsigned h_total(input vga_timing_t t);
        return t.h.active + t.h.fp + t.h.sync + t.h.bp;
    endfunction

    function automatic int unsigned v_total(input vga_timing_t t);
        return t.v.active + t.v.fp + t.v.sync + t.v.bp;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Tick-enabled shift register with synchronous clear; aligns sync/blank with pixel data.
module vga_delay_line #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 1
) (
    input  logic             CLOCK_50,
    input  logic             clear,
    input  logic             tick,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    if (DEPTH == 0) begin : g_wire
        logic unused_ok;
        assign unused_ok = &{1'b0, CLOCK_50, clear, tick};
        assign dout      = din;
    end else begin : g_shift
        logic [DEPTH-1:0][WIDTH-1:0] stage;

        always_ff @(posedge CLOCK_50) begin
            if (clear) begin
                stage <= '0;
            end else if (tick) begin
                stage[0] <= din;
                for (int i = 1; i < DEPTH; i++) begin
                    stage[i] <= stage[i-1];
                end
            end
        end

        assign dout = stage[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Programmable VGA timing generator: fetch address runs LAT ticks ahead of the
// registered sync/blank/RGB outputs so frame-buffer read latency is hidden.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE   = int'(VGA_640x480.h.active),
    parameter int H_FP       = int'(VGA_640x480.h.fp),
    parameter int H_SYNC     = int'(VGA_640x480.h.sync),
    parameter int H_BP       = int'(VGA_640x480.h.bp),
    parameter int V_ACTIVE   = int'(VGA_640x480.v.active),
    parameter int V_FP       = int'(VGA_640x480.v.fp),
    parameter int V_SYNC     = int'(VGA_640x480.v.sync),
    parameter int V_BP       = int'(VGA_640x480.v.bp),
    parameter int HS_POL     = 0,
    parameter int VS_POL     = 0,
    parameter int CLK_DIV    = 2,
    parameter int LAT        = 1,
    parameter int COLOR_MODE = 0,
    parameter int PIXEL_BITS = 2,
    parameter int X_W        = 10,
    parameter int Y_W        = 9
) (
    input  logic                  CLOCK_50,
    input  logic                  Reset,
    input  logic                  enable,
    input  logic [PIXEL_BITS-1:0] pixel,
    output logic [X_W-1:0]        pixel_x,
    output logic [Y_W-1:0]        pixel_y,
    output logic                  pixel_req,
    output logic                  frame_start,
    output logic                  line_start,
    output logic [7:0]            VGA_R,
    output logic [7:0]            VGA_G,
    output logic [7:0]            VGA_B,
    output logic                  VGA_HS,
    output logic                  VGA_VS,
    output logic                  VGA_CLK,
    output logic                  VGA_BLANK_N
);

    localparam vga_timing_t TIMING = '{
        h: '{active: H_ACTIVE, fp: V_FP * 0 + H_FP, sync: H_SYNC, bp: H_BP},
        v: '{active: V_ACTIVE, fp: V_FP, sync: V_SYNC, bp: V_BP}
    };
    localparam int H_TOTAL = int'(h_total(TIMING));
    localparam int V_TOTAL = int'(v_total(TIMING));
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int DW      = $clog2(CLK_DIV);

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [HW:0]   HS_START = (HW+1)'(H_ACTIVE + H_FP);
    localparam logic [HW:0]   HS_END   = (HW+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW:0]   VS_START = (VW+1)'(V_ACTIVE + V_FP);
    localparam logic [VW:0]   VS_END   = (VW+1)'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic          HS_ON    = (HS_POL != 0);
    localparam logic          VS_ON    = (VS_POL != 0);
    localparam color_mode_e   MODE     = color_mode_e'(COLOR_MODE);
    localparam int            MIN_PIX  = (COLOR_MODE == 2) ? 8 : (COLOR_MODE == 1) ? 3 : 1;

    if (CLK_DIV < 2 || (CLK_DIV % 2) != 0) begin : g_bad_div
        $error("CLK_DIV must be even and at least 2");
    end
    if (H_ACTIVE > (2 ** X_W)) begin : g_bad_xw
        $error("X_W too narrow for H_ACTIVE");
    end
    if (PIXEL_BITS < MIN_PIX || LAT < 0 || LAT > 7) begin : g_bad_pix
        $error("PIXEL_BITS too small for COLOR_MODE, or LAT outside 0..7");
    end

    logic [DW-1:0] div_cnt;
    logic          run;
    logic          vga_clk_q;
    logic [HW-1:0] h;
    logic [VW-1:0] v;
    logic          tick, go, clear;
    logic          in_active, hs_raw, vs_raw;
    logic [2:0]    raw_q, disp;
    logic [7:0]    px;
    logic [23:0]   rgb_map;

    assign tick      = (div_cnt == DIV_LAST);
    assign clear     = Reset || !enable;
    // run lags enable by a cycle so the tick after re-enable starts cleanly from div_cnt=0
    assign go        = enable && run && tick;
    assign in_active = (h < H_ACT) && (v < V_ACT);
    assign hs_raw    = ({1'b0, h} >= HS_START) && ({1'b0, h} < HS_END);
    assign vs_raw    = ({1'b0, v} >= VS_START) && ({1'b0, v} < VS_END);

    always_ff @(posedge CLOCK_50) begin
        if (Reset) begin
            div_cnt   <= '0;
            run       <= 1'b1;
            vga_clk_q <= 1'b0;
        end else begin
            run       <= enable;
            vga_clk_q <= (div_cnt >= DIV_HALF);
            if ((enable != run) || tick) div_cnt <= '0;
            else                         div_cnt <= div_cnt + DW'(1);
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (clear) begin
            h <= '0;
            v <= '0;
        end else if (go) begin
            if (h == H_LAST) begin
                h <= '0;
                v <= (v == V_LAST) ? '0 : v + VW'(1);
            end else begin
                h <= h + HW'(1);
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (clear) begin
            pixel_req   <= 1'b0;
            pixel_x     <= '0;
            pixel_y     <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            raw_q       <= '0;
        end else begin
            line_start  <= go && (h == '0);
            frame_start <= go && (h == '0) && (v == '0);
            if (go) begin
                pixel_req <= in_active;
                pixel_x   <= in_active ? X_W'(h) : '0;
                pixel_y   <= in_active ? Y_W'(v) : '0;
                raw_q     <= {hs_raw, vs_raw, in_active};
            end
        end
    end

    vga_delay_line #(.WIDTH(3), .DEPTH(LAT)) u_delay (
        .CLOCK_50 (CLOCK_50),
        .clear    (clear),
        .tick     (go),
        .din      (raw_q),
        .dout     (disp)
    );

    assign px = 8'(pixel);

    always_comb begin
        rgb_map = '0;
        case (MODE)
            CM_MONO:   rgb_map[15:8] = (pixel != '0) ? 8'hFF : 8'h00;
            CM_RGB111: rgb_map = {{8{px[0]}}, {8{px[1]}}, {8{px[2]}}};
            CM_RGB332: rgb_map = {px[7:5], px[7:5], px[7:6],
                                  px[4:2], px[4:2], px[4:3],
                                  {4{px[1:0]}}};
            default:   rgb_map = '0;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (clear) begin
            VGA_HS                <= ~HS_ON;
            VGA_VS                <= ~VS_ON;
            VGA_BLANK_N           <= 1'b0;
            {VGA_R, VGA_G, VGA_B} <= '0;
        end else if (go) begin
            VGA_HS                <= disp[2] ? HS_ON : ~HS_ON;
            VGA_VS                <= disp[1] ? VS_ON : ~VS_ON;
            VGA_BLANK_N           <= disp[0];
            {VGA_R, VGA_G, VGA_B} <= disp[0] ? rgb_map : 24'h0;
        end
    end

    assign VGA_CLK = vga_clk_q;

endmodule
